// File: rtl/mux_4to1_rr_arb.sv
// mux_4to1_rr_arb: four-way arbiter owning the select of a 4:1 mux.
// Default build arbitrates round-robin. Defining MUX_ARB_FIXED_PRIO_EN
// switches to fixed priority (req[0] highest), and that build carries no
// rotation pointer.
// Each grant is one burst of up to HOLD accepted beats. After every grant
// the arbiter spends one cycle in IDLE.

module mux_4to1_rr_arb #(
   parameter int unsigned DATA_W = 1,
   parameter int unsigned HOLD   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   input  logic [DATA_W-1:0] in_d,
   input  logic              out_ready,
   output logic [1:0]        sel,
   output logic [3:0]        gnt,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [1:0]       sel_n;
   logic [3:0]       gnt_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       win;
   logic             found;

`ifdef MUX_ARB_FIXED_PRIO_EN
   // Winner is the lowest set request index.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!found && req[k]) begin
            win   = 2'(k);
            found = 1'b1;
         end
      end
   end
`else
   logic [1:0] ptr, ptr_n;
   logic [1:0] idx;

   // Winner is the first set request after the last granted index.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Rotation pointer: remembers the last granted index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 2'd3;
      end else begin
         ptr <= ptr_n;
      end
   end
`endif

   // State, select, grant and beat-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 2'd0;
         gnt   <= 4'd0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         gnt   <= gnt_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic plus the valid/last handshake outputs.
   always_comb begin
      state_n   = state;
      sel_n     = sel;
      gnt_n     = gnt;
      cnt_n     = cnt;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_n     = ptr;
`endif
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               sel_n   = win;
               gnt_n   = 4'b0001 << win;
               cnt_n   = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            out_valid = req[sel];
            out_last  = req[sel] && (cnt == LAST_BEAT);
            // Release on withdrawal or on the final accepted beat.
            if (!req[sel] || (out_ready && (cnt == LAST_BEAT))) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
               ptr_n   = sel;
`endif
               gnt_n   = 4'd0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (out_ready) begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Shared 4:1 datapath mux, steered by the registered select.
   always_comb begin
      case (sel)
         2'd0:    out_data = in_a;
         2'd1:    out_data = in_b;
         2'd2:    out_data = in_c;
         default: out_data = in_d;
      endcase
   end

endmodule

// File: tb/tb_mux_4to1_rr_arb.sv
// Directed bench for mux_4to1_rr_arb: a HOLD=4 instance plus a HOLD=1 instance.
// Expected grant orders follow MUX_ARB_FIXED_PRIO_EN when it is defined.

module tb_mux_4to1_rr_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] req1;
   logic       in_a, in_b, in_c, in_d;
   logic       out_ready;
   logic [1:0] sel, sel1;
   logic [3:0] gnt, gnt1;
   logic       out_data, out_data1;
   logic       out_valid, out_valid1;
   logic       out_last, out_last1;

   int pass_cnt = 0;
   int total    = 0;

   // Data driven on in_a..in_d, indexed by requester.
   logic dv [4];

   mux_4to1_rr_arb #(.DATA_W(1), .HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
      .out_ready(out_ready), .sel(sel), .gnt(gnt),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
   );

   mux_4to1_rr_arb #(.DATA_W(1), .HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
      .out_ready(out_ready), .sel(sel1), .gnt(gnt1),
      .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int order [5];
      int order1 [4];
      logic rdy [6];
      int acc;

`ifdef MUX_ARB_FIXED_PRIO_EN
      order  = '{0, 0, 0, 0, 0};
      order1 = '{0, 0, 0, 0};
`else
      order  = '{0, 1, 2, 3, 0};
      order1 = '{0, 1, 0, 1};
`endif
      rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      in_a = 1'b1; in_b = 1'b0; in_c = 1'b1; in_d = 1'b0;
      dv = '{1'b1, 1'b0, 1'b1, 1'b0};
      rst_n = 1'b0; req = 4'd0; req1 = 4'd0; out_ready = 1'b1;

      // Reset state.
      step(); step();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'(in_a));

      // Single request from requester 2.
      rst_n = 1'b1;
      req = 4'b0100;
      step();
      chk("single_sel", 32'(sel), 32'd2);
      for (int i = 0; i < 4; i++) begin
         chk("single_gnt", 32'(gnt), 32'b0100);
         chk("single_valid", 32'(out_valid), 32'd1);
         chk("single_data", 32'(out_data), 32'd1);
         chk("single_last", 32'(out_last), 32'(i == 3));
         step();
      end
      chk("single_idle_gnt", 32'(gnt), 32'd0);
      chk("single_idle_valid", 32'(out_valid), 32'd0);
      step();
      chk("single_regrant", 32'(gnt), 32'b0100);

      // Reset asserted during beat 2 acts without a clock edge.
      step();
      #2;
      rst_n = 1'b0;
      req = 4'b1111;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_sel", 32'(sel), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Continuous requests: rotation with one idle cycle per grant.
      for (int g = 0; g < 5; g++) begin
         chk("rot_sel", 32'(sel), 32'(order[g]));
         chk("rot_gnt", 32'(gnt), 32'(4'b0001 << order[g]));
         for (int b = 0; b < 4; b++) begin
            chk("rot_valid", 32'(out_valid), 32'd1);
            chk("rot_data", 32'(out_data), 32'(dv[order[g]]));
            chk("rot_last", 32'(out_last), 32'(b == 3));
            step();
         end
         chk("rot_idle_gnt", 32'(gnt), 32'd0);
         chk("rot_idle_valid", 32'(out_valid), 32'd0);
         if (g == 4) req = 4'b0010;
         step();
      end

      // Back-pressure on requester 1.
      acc = 0;
      chk("bp_sel", 32'(sel), 32'd1);
      for (int i = 0; i < 6; i++) begin
         out_ready = rdy[i];
         #1;
         chk("bp_gnt", 32'(gnt), 32'b0010);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_last", 32'(out_last), 32'(acc == 3));
         step();
         if (rdy[i]) acc++;
      end
      chk("bp_release", 32'(gnt), 32'd0);

      // Withdrawal by requester 3 after two accepted beats.
      out_ready = 1'b1;
      req = 4'b1000;
      step();
      chk("wd_gnt", 32'(gnt), 32'b1000);
      step(); step();
      req = 4'b0101;
      #1;
      chk("wd_valid", 32'(out_valid), 32'd0);
      chk("wd_last", 32'(out_last), 32'd0);
      step();
      chk("wd_idle_gnt", 32'(gnt), 32'd0);
      step();
      chk("wd_next_sel", 32'(sel), 32'd0);
      chk("wd_next_gnt", 32'(gnt), 32'b0001);
      req = 4'd0;

      // HOLD=1 instance: single-beat grants.
      req1 = 4'b0011;
      step();
      for (int g = 0; g < 4; g++) begin
         chk("h1_sel", 32'(sel1), 32'(order1[g]));
         chk("h1_gnt", 32'(gnt1), 32'(4'b0001 << order1[g]));
         chk("h1_valid", 32'(out_valid1), 32'd1);
         chk("h1_last", 32'(out_last1), 32'd1);
         step();
         chk("h1_idle_gnt", 32'(gnt1), 32'd0);
         chk("h1_idle_last", 32'(out_last1), 32'd0);
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/mux_4to1_rr_arb.md
# mux_4to1_rr_arb

Round-robin arbiter that shares one 4:1 multiplexer datapath between four requesters. It samples four request lines and owns the mux select. It grants one requester at a time for a bounded burst and presents the selected input on a valid/ready output. It sits directly in front of the 4:1 mux: its registered select drives the mux, and the mux output becomes the block's output data.

## Interface
- DATA_W, 1: width of each requester's data input and of out_data
- HOLD, 4: maximum accepted beats per grant; legal range 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request lines; bit i belongs to requester i
- in_a  in  DATA_W  requester 0 data
- in_b  in  DATA_W  requester 1 data
- in_c  in  DATA_W  requester 2 data
- in_d  in  DATA_W  requester 3 data
- out_ready  in  1  downstream accepts a beat when high together with out_valid
- sel  out  2  registered mux select: 0=in_a, 1=in_b, 2=in_c, 3=in_d
- gnt  out  4  registered one-hot grant; all zero when idle
- out_data  out  DATA_W  combinational mux output (in_a/in_b/in_c/in_d chosen by sel)
- out_valid  out  1  high in GRANT while req[sel] is high
- out_last  out  1  high with out_valid on the final allowed beat (count == HOLD-1)

## Operation
- The FSM has two states, IDLE and GRANT. Registers: sel, gnt, ptr[1:0] (last granted index), cnt[3:0] (beats accepted in the current grant).
- Reset values: state=IDLE, sel=0, gnt=0, ptr=3, cnt=0. Outputs follow: out_valid=0, out_last=0, out_data=in_a.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick the first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Load sel=winner, gnt=1<<winner, cnt=0, and move to GRANT.
- GRANT:
  - out_valid = req[sel].
  - Beat accepted = out_valid & out_ready; each accepted beat increments cnt.
  - Release when the accepted beat has cnt==HOLD-1, or when req[sel]==0 (the requester withdrew).
  - On release: ptr=sel, gnt=0, cnt=0, and return to IDLE. sel keeps its value.
- Back-pressure: when out_ready is low, no beat is accepted, cnt holds, and the grant holds indefinitely while req[sel] stays high.
- Requests from other requesters during GRANT are ignored until the next IDLE cycle.
- Reset asserted mid-burst immediately forces the reset values, including asynchronously dropping gnt and out_valid.

## Timing
- Arbitration latency: req rising in cycle N (FSM in IDLE) gives gnt/sel valid and out_valid in cycle N+1.
- Every grant is followed by exactly one IDLE cycle; there is no back-to-back grant.
  - Throughput under continuous requests: HOLD beats per HOLD+1 cycles.
- out_data is combinational from sel and the data inputs, with no added latency.
- out_valid and out_last are combinational from state, req, and cnt.
- HOLD=1: every grant is a single beat, and out_last is high on every valid beat.

## Configuration
- MUX_ARB_FIXED_PRIO_EN defined: priority is fixed, with req[0] highest and req[3] lowest. ptr is not implemented; IDLE always picks the lowest set index. Timing and burst limits are unchanged.
- MUX_ARB_FIXED_PRIO_EN undefined (default): round-robin arbitration as described under Operation.

## Test plan
- Reset then single request:
  - Stimulus: rst_n low then released, req=4'b0100, in_c=1, out_ready=1.
  - Required: sel=2 and gnt=4'b0100 in the cycle after; out_valid=1 and out_data=1 for 4 cycles; out_last on the 4th; then one IDLE cycle with gnt=0; then regrant to requester 2.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held, out_ready=1.
  - Required: grant order is 0,1,2,3,0. Each burst is 4 beats followed by one idle cycle.
  - With MUX_ARB_FIXED_PRIO_EN defined: grant order is 0,0,0.
- Back-pressure:
  - Stimulus: requester 1 granted; out_ready toggles 1,0,0,1,1,1.
  - Required: cnt advances only on ready cycles, out_last coincides with the 4th accepted beat, and gnt is held throughout.
- Withdrawal:
  - Stimulus: requester 3 granted; req[3] drops after 2 accepted beats.
  - Required: out_valid=0 in that cycle; IDLE next cycle; ptr=3, so a pending req[0] wins next.
- Reset mid-burst:
  - Stimulus: rst_n low during beat 2 of a grant.
  - Required: gnt=0, sel=0, out_valid=0 immediately, without waiting for a clock edge; after release, the first grant goes to the lowest pending index.
- HOLD=1 build:
  - Stimulus: req=4'b0011, out_ready=1.
  - Required: alternating single-beat grants 0,1,0,1; out_last high on every valid beat.
